// File: rtl/alu_pkg.sv
// Shared opcode and FSM-state encodings for the sequenced ALU and its controller decoder.
package alu_pkg;

    localparam int ALU_OP_W = 3;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_MVN = 3'b011,
        OP_LSL = 3'b100,
        OP_LSR = 3'b101,
        OP_ASR = 3'b110,
        OP_MUL = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

    function automatic logic op_is_mul(input alu_op_t o);
        return o == OP_MUL;
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier: loads on start, then one partial product per cycle for WIDTH cycles.
// done and product are combinational during the final step so the caller can register the result on that edge.
module alu_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc_q, mcand_q, acc_d;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;

    assign acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign product = acc_d;
    assign done    = busy_q && (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            // No early exit on zero operands: latency is always WIDTH steps.
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with status flags: single-cycle ops register on the accept edge, MUL completes WIDTH edges later.
// Result is held while out_ready is low; in_ready follows out_ready combinationally in DONE.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
    input  logic             set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             Z,
    output logic             N,
    output logic             V
);

    import alu_pkg::*;

    localparam int MSB = WIDTH - 1;
    localparam int SHW = $clog2(WIDTH);

    alu_state_t         state_q;
    logic [WIDTH-1:0]   result_q, res_d;
    logic               out_valid_q, z_q, n_q, v_q, v_d;
    logic               flag_en_q;
    logic               accept, mul_start, mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [SHW-1:0]     shamt;
    alu_op_t            op_in;

    assign op_in     = alu_op_t'(op);
    assign shamt     = bin[SHW-1:0];
    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && op_is_mul(op_in);

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign Z         = z_q;
    assign N         = n_q;
    assign V         = v_q;

    always_comb begin
        res_d = '0;
        v_d   = 1'b0;
        unique case (op_in)
            OP_ADD: begin
                res_d = ain + bin;
                v_d   = (ain[MSB] == bin[MSB]) && (res_d[MSB] != ain[MSB]);
            end
            OP_SUB: begin
                res_d = ain - bin;
                v_d   = (ain[MSB] != bin[MSB]) && (res_d[MSB] != ain[MSB]);
            end
            OP_AND:  res_d = ain & bin;
            OP_MVN:  res_d = ~bin;
            OP_LSL:  res_d = ain << shamt;
            OP_LSR:  res_d = ain >> shamt;
            OP_ASR:  res_d = $signed(ain) >>> shamt;
            default: res_d = '0;
        endcase
    end

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (ain),
        .b       (bin),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            v_q         <= 1'b0;
            flag_en_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        flag_en_q <= set_flags;
                        if (op_is_mul(op_in)) begin
                            state_q     <= ST_MUL;
                            out_valid_q <= 1'b0;
                        end else begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= res_d;
                            if (set_flags) begin
                                z_q <= (res_d == '0);
                                n_q <= res_d[MSB];
                                v_q <= v_d;
                            end
                        end
                    end else if ((state_q == ST_DONE) && out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= mul_product[WIDTH-1:0];
                        // set_flags was captured at acceptance; the live input may have moved on.
                        if (flag_en_q) begin
                            z_q <= (mul_product[WIDTH-1:0] == '0);
                            n_q <= mul_product[MSB];
                            v_q <= |mul_product[2*WIDTH-1:WIDTH];
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
